// File: rtl/fir_mac_sequencer.sv
// Serial FIR: circular delay line plus one shared multiply-accumulate stepping over all N+1 taps.
// Results leave on a valid/ready port; coefficients are writable only while idle.
module fir_mac_sequencer #(
    parameter int N       = 5,
    parameter int WIDTH_X = 8,
    parameter int WIDTH_B = 3,
    localparam int WIDTH_Y = WIDTH_X + WIDTH_B + N + 1,
    localparam int ADDR_W  = ($clog2(N + 1) > 1) ? $clog2(N + 1) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH_X-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH_Y-1:0] m_data,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [WIDTH_B-1:0] cfg_data,
    output logic               cfg_err,
    output logic               busy
);
    localparam int PROD_W = WIDTH_X + WIDTH_B;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                     state_reg, state_next;
    logic [ADDR_W-1:0]          wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0]          tap_reg, tap_next;
    logic [ADDR_W-1:0]          rd_idx;
    logic signed [WIDTH_Y-1:0]  acc_reg, acc_next;
    logic signed [WIDTH_Y-1:0]  m_data_reg, m_data_next;
    logic signed [WIDTH_Y-1:0]  sum;
    logic signed [PROD_W-1:0]   prod;
    logic signed [WIDTH_X-1:0]  line_reg [0:N];
    logic signed [WIDTH_B-1:0]  coef_reg [0:N];
    logic                       cfg_err_reg;
    logic                       cfg_ok;
    logic                       line_we;

    // Tap k reads the sample k steps older than the newest one, wrapping modulo N+1.
    always_comb begin
        if (tap_reg <= wr_ptr_reg)
            rd_idx = wr_ptr_reg - tap_reg;
        else
            rd_idx = ADDR_W'(int'(wr_ptr_reg) + N + 1 - int'(tap_reg));
    end

    assign prod = PROD_W'(coef_reg[tap_reg]) * PROD_W'(line_reg[rd_idx]);
    assign sum  = acc_reg + {{(WIDTH_Y - PROD_W){prod[PROD_W-1]}}, prod};

    assign cfg_ok = cfg_we && (state_reg == IDLE) && (cfg_addr <= LAST);

    always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg;
        tap_next    = tap_reg;
        acc_next    = acc_reg;
        m_data_next = m_data_reg;
        line_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_valid) begin
                    line_we    = 1'b1;
                    acc_next   = '0;
                    tap_next   = '0;
                    state_next = MAC;
                end
            end
            MAC: begin
                acc_next = sum;
                tap_next = tap_reg + 1'b1;
                if (tap_reg == LAST) begin
                    m_data_next = sum;
                    wr_ptr_next = (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
                    tap_next    = '0;
                    state_next  = OUT;
                end
            end
            OUT: begin
                if (m_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= '0;
            tap_reg     <= '0;
            acc_reg     <= '0;
            m_data_reg  <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_next;
            tap_reg     <= tap_next;
            acc_reg     <= acc_next;
            m_data_reg  <= m_data_next;
            cfg_err_reg <= cfg_we && !cfg_ok;
        end
    end

    // Delay line and coefficient bank; a coefficient written on the accept edge feeds that sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i <= N; i++) begin
                line_reg[i] <= '0;
                coef_reg[i] <= '0;
            end
        end else begin
            if (line_we)
                line_reg[wr_ptr_reg] <= s_data;
            if (cfg_ok)
                coef_reg[cfg_addr] <= cfg_data;
        end
    end

    assign s_ready = (state_reg == IDLE);
    assign m_valid = (state_reg == OUT);
    assign busy    = (state_reg != IDLE);
    assign m_data  = m_data_reg;
    assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed and random checks of fir_mac_sequencer against a convolution model
// built from a coefficient array and a newest-first sample history.
module tb_fir_mac_sequencer;
    localparam int N = 5;
    localparam int WIDTH_X = 8;
    localparam int WIDTH_B = 3;
    localparam int WIDTH_Y = WIDTH_X + WIDTH_B + N + 1;
    localparam int ADDR_W = 3;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [WIDTH_X-1:0] s_data = '0;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic [WIDTH_Y-1:0] m_data;
    logic               cfg_we = 1'b0;
    logic [ADDR_W-1:0]  cfg_addr = '0;
    logic [WIDTH_B-1:0] cfg_data = '0;
    logic               cfg_err;
    logic               busy;

    int vectors = 0;
    int miscompares = 0;
    int b [0:N];
    int hist [$];

    fir_mac_sequencer #(.N(N), .WIDTH_X(WIDTH_X), .WIDTH_B(WIDTH_B)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_y();
        int s = 0;
        for (int k = 0; k <= N && k < hist.size(); k++)
            s += b[k] * hist[k];
        return s;
    endfunction

    task automatic model_push(input int x);
        hist.push_front(x);
        if (hist.size() > N + 1)
            void'(hist.pop_back());
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k <= N; k++) b[k] = 0;
    endtask

    task automatic write_coef(input int k, input int v, input bit exp_err);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = ADDR_W'(k); cfg_data = WIDTH_B'(v);
        @(negedge clk);
        cfg_we = 1'b0;
        check("cfg_err_pulse", cfg_err, exp_err);
        if (!exp_err) b[k] = v;
        @(negedge clk);
        check("cfg_err_clear", cfg_err, 0);
    endtask

    // One full transaction with m_ready high; optional coefficient write on the accept edge.
    task automatic run_sample(input int x, input bit cfg_en, input int ck, input int cv);
        int cnt;
        @(negedge clk);
        check("s_ready_idle", s_ready, 1);
        s_valid = 1'b1; s_data = WIDTH_X'(x); m_ready = 1'b1;
        if (cfg_en) begin
            cfg_we = 1'b1; cfg_addr = ADDR_W'(ck); cfg_data = WIDTH_B'(cv);
            b[ck] = cv;
        end
        model_push(x);
        @(negedge clk);
        s_valid = 1'b0; cfg_we = 1'b0; cnt = 1;
        if (cfg_en) check("cfg_err_coincident", cfg_err, 0);
        while (m_valid !== 1'b1 && cnt < 40) begin
            @(negedge clk); cnt++;
        end
        check("latency", cnt, N + 2);
        check("m_data", $signed(m_data), model_y());
        $display("sample x=%0d -> m_data=%0d (model %0d) latency=%0d", x, $signed(m_data), model_y(), cnt);
        @(negedge clk);
        check("m_valid_drop", m_valid, 0);
    endtask

    initial begin
        int imp_exp [0:6];
        int cnt;
        logic signed [31:0] held;
        imp_exp = '{10, 20, 30, -10, -20, -40, 0};
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_m_data", $signed(m_data), 0);

        // Impulse response
        write_coef(0, 1, 0); write_coef(1, 2, 0); write_coef(2, 3, 0);
        write_coef(3, -1, 0); write_coef(4, -2, 0); write_coef(5, -4, 0);
        run_sample(10, 0, 0, 0);
        check("impulse0", $signed(m_data), imp_exp[0]);
        for (int i = 1; i < 7; i++) begin
            run_sample(0, 0, 0, 0);
            check("impulse", $signed(m_data), imp_exp[i]);
        end

        // Backpressure with a pending sample that must not be taken
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'd25; m_ready = 1'b0;
        model_push(25);
        @(negedge clk);
        s_valid = 1'b0; cnt = 1;
        while (m_valid !== 1'b1 && cnt < 40) begin
            @(negedge clk); cnt++;
        end
        check("bp_latency", cnt, N + 2);
        check("bp_m_data", $signed(m_data), model_y());
        held = $signed(m_data);
        s_valid = 1'b1; s_data = 8'd99;
        repeat (5) begin
            @(negedge clk);
            check("bp_m_valid", m_valid, 1);
            check("bp_m_data_stable", $signed(m_data), held);
            check("bp_s_ready", s_ready, 0);
        end
        m_ready = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        check("bp_release_m_valid", m_valid, 0);
        check("bp_release_s_ready", s_ready, 1);
        check("bp_m_data_kept", $signed(m_data), held);

        // Extremes
        for (int k = 0; k <= N; k++) write_coef(k, -4, 0);
        for (int i = 0; i <= N; i++) run_sample(-128, 0, 0, 0);
        check("extreme_pos", $signed(m_data), 3072);
        for (int k = 0; k <= N; k++) write_coef(k, 3, 0);
        for (int i = 0; i <= N; i++) run_sample(-128, 0, 0, 0);
        check("extreme_neg", $signed(m_data), -2304);

        // Config protection
        write_coef(0, 1, 0); write_coef(1, 1, 0); write_coef(2, -2, 0);
        write_coef(3, 1, 0); write_coef(4, 1, 0); write_coef(5, 1, 0);
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'd7; m_ready = 1'b1;
        model_push(7);
        @(negedge clk);
        s_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 3'd3;
        @(negedge clk);
        cfg_we = 1'b0; cnt = 2;
        check("cfg_mac_err", cfg_err, 1);
        check("cfg_mac_busy", busy, 1);
        while (m_valid !== 1'b1 && cnt < 40) begin
            @(negedge clk); cnt++;
        end
        check("cfg_mac_latency", cnt, N + 2);
        check("cfg_mac_unchanged", $signed(m_data), model_y());
        @(negedge clk);
        write_coef(6, 1, 1);
        run_sample(3, 0, 0, 0);
        run_sample(-5, 1, 1, -3);

        // Pointer wrap over a ramp
        write_coef(0, 1, 0); write_coef(1, 0, 0); write_coef(2, 0, 0);
        write_coef(3, 0, 0); write_coef(4, 0, 0); write_coef(5, 1, 0);
        for (int i = 1; i <= 20; i++) run_sample(i, 0, 0, 0);
        check("ramp_last", $signed(m_data), 20 + 15);

        // Reset mid-MAC at tap 3
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'd55; m_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_s_ready", s_ready, 1);
        check("midrst_m_data", $signed(m_data), 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        write_coef(0, 2, 0); write_coef(1, -1, 0); write_coef(2, 1, 0);
        write_coef(3, 3, 0); write_coef(4, -4, 0); write_coef(5, 1, 0);
        run_sample(10, 0, 0, 0);
        check("post_rst_first", $signed(m_data), 20);
        for (int i = 0; i < N; i++) run_sample(0, 0, 0, 0);
        check("post_rst_last", $signed(m_data), 10);

        // Random coefficients, samples and coincident writes
        for (int k = 0; k <= N; k++) write_coef(k, int'($urandom_range(0, 7)) - 4, 0);
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0)
                run_sample(int'($urandom_range(0, 255)) - 128, 1,
                           int'($urandom_range(0, N)), int'($urandom_range(0, 7)) - 4);
            else
                run_sample(int'($urandom_range(0, 255)) - 128, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
